ps2_rx: RTL
===========

# ps2_rx

PS/2 keyboard receiver that deserializes 11-bit device-to-host frames from the raw `ps2_clk`/`ps2_dat` pins and presents each accepted scan-code byte as a one-cycle strobe. It sits directly upstream of the port controller's keyboard path and drives its `ps2_data`/`ps2_hit` inputs in the 50 MHz domain. All AT→XT translation and break-code (F0) handling stays downstream; this block only frames, checks and delivers bytes.

## Interface
- `FILTER`, 8: cycles a synchronized `ps2_clk` level must hold before the filtered level changes; legal range 2..255.
- `TIMEOUT`, 10000: max cycles between filtered falling edges inside a frame (200 µs at 50 MHz); legal range ≥ 16.
- `clock` in 1: 50 MHz system clock (the port controller's `clock50`); all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_dat` in 1: raw PS/2 data pin, asynchronous.
- `ps2_data` out 8: last accepted byte; held until the next accepted frame.
- `ps2_hit` out 1: one-cycle strobe, `ps2_data` valid in the same cycle.
- `ps2_err` out 1: one-cycle strobe on framing, parity or timeout error.

## Operation
- Both pins pass through 2-flop synchronizers (reset value 1).
- Glitch filter: filtered clock changes only after the synchronized value differs from it for `FILTER` consecutive cycles; any agreement clears the counter.
- Falling edge of the filtered clock = sample strobe; data sampled from the synchronized `ps2_dat` in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data 0 → DATA, bit counter 0. Strobe with data 1 → stay IDLE, `ps2_err` pulse.
  - DATA: shift in LSB first; after 8th bit → PARITY.
  - PARITY: capture parity bit; odd parity: XOR of 8 data bits and parity bit must be 1.
  - STOP: capture stop bit; → IDLE. If stop = 1 and parity good: load `ps2_data`, pulse `ps2_hit`. Otherwise pulse `ps2_err`, `ps2_data` unchanged.
- Timeout counter clears on every strobe and while in IDLE; in any other state reaching `TIMEOUT` → IDLE, `ps2_err` pulse, partial byte discarded.
- `ps2_hit` and `ps2_err` never assert in the same cycle.
- No host-to-device transmission; pins are inputs only.

## Timing
- Reset values: `ps2_data` 8'h00, `ps2_hit` 0, `ps2_err` 0, FSM IDLE, all counters 0, filtered clock 1.
- Pin-to-strobe: 2 sync cycles + `FILTER` cycles + 1 edge-detect cycle after the raw falling edge.
- `ps2_hit`/`ps2_err` registered, asserted the cycle after the stop-bit strobe (or the timeout cycle), exactly one cycle wide.
- Back-to-back frames: minimum inter-strobe gap is set by the device (~30 µs), far above latency; no buffering needed.
- Reset asserted mid-frame: immediate return to reset values; bits before reset are never delivered; first falling edge after release is treated as a potential start bit.
- Counter widths: filter `$clog2(FILTER+1)`, timeout `$clog2(TIMEOUT+1)`, bit counter 3 bits; no wrap permitted (saturate at terminal value).

## Configuration
- `PS2_PARITY_EN` defined: parity checked as above; bad parity → `ps2_err`, no `ps2_hit`.
- Undefined: parity bit sampled and ignored; frame accepted on stop = 1 alone; no parity logic synthesized.

## Structure
- Package `ps2_pkg`: FSM state enum (IDLE, DATA, PARITY, STOP), `PS2_FRAME_BITS = 11`, default `FILTER`/`TIMEOUT` constants.
- Sub-module `ps2_filter`: synchronizers, glitch filter and falling-edge strobe; `ps2_rx` holds FSM, shift register, parity and timeout.

## Test plan
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1; 4000-cycle PS/2 period) → one `ps2_hit`, `ps2_data` = 8'h1C, no `ps2_err`.
- Frames 0xF0 then 0x1C back-to-back → two `ps2_hit` pulses, data F0 then 1C; `ps2_data` holds 1C afterward.
- 0x1C with parity 1 → `PS2_PARITY_EN`: one `ps2_err`, no hit, `ps2_data` unchanged; without macro: hit with 8'h1C.
- 3-cycle low glitch on `ps2_clk` in IDLE with `FILTER` = 8 → no strobe, no hit, no error, FSM stays IDLE.
- Start + 4 data bits, then clock held high → `ps2_err` exactly `TIMEOUT` (10000) cycles after the last strobe plus one; next full frame 0x5A → hit, `ps2_data` = 8'h5A.
- `resetn` low for 1 cycle after bit 5 of a frame → outputs at reset values, no hit; subsequent full frame 0x29 → hit, `ps2_data` = 8'h29.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared FSM state type, frame geometry and default timing constants for the PS/2 receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional build macro used by importers: PS2_PARITY_EN (enables odd-parity checking).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_FILTER_DEF  = 8;
  localparam int PS2_TIMEOUT_DEF = 10000;

  // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 pins, de-glitches the clock and emits a falling-edge sample strobe.
// Latency: 2 sync cycles + FILTER cycles + 1 edge-detect cycle from raw clock fall to fall_stb.
// Backpressure: none; fall_stb is a single-cycle pulse the consumer must take when it appears.
//
// Ports:
//   clock, resetn      : system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat   : raw asynchronous pins
//   fall_stb           : one-cycle pulse on a filtered clock falling edge
//   dat_sync           : synchronized data pin, valid to sample while fall_stb is high
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = PS2_FILTER_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall_stb,
  output logic dat_sync
);

  localparam int CNT_W = $clog2(FILTER + 1);

  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic             filt_q, filt_d;
  logic             filt_dly_q, filt_dly_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      stb_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      stb_q      <= stb_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    filt_d     = filt_q;
    filt_dly_d = filt_q;
    cnt_d      = '0;
    // Count consecutive disagreeing samples; the FILTER-th one flips the filtered level.
    // Any agreeing sample leaves cnt_d at its zero default.
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    stb_d = filt_dly_q & ~filt_q;
  end

  assign fall_stb = stb_q;
  assign dat_sync = dat_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: frames, checks and delivers one scan-code byte per frame.
// Latency: ps2_hit/ps2_err rise one cycle after the stop-bit strobe (or the timeout cycle).
// Backpressure: none; ps2_hit/ps2_err are one-cycle strobes, ps2_data holds until the next good frame.
//
// Ports:
//   clock, resetn      : 50 MHz system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat   : raw asynchronous PS/2 pins (receive only)
//   ps2_data           : last accepted byte
//   ps2_hit            : one-cycle strobe, ps2_data valid in the same cycle
//   ps2_err            : one-cycle strobe on start/stop framing, parity or timeout error
// Build macro: PS2_PARITY_EN -- when defined, odd parity is checked and a bad parity
// bit rejects the frame; otherwise the parity bit is sampled and ignored.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = PS2_FILTER_DEF,
  parameter int TIMEOUT = PS2_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err
);

  localparam int TOUT_W = $clog2(TIMEOUT + 1);

  logic stb;
  logic dat;

  ps2_filter #(
    .FILTER (FILTER)
  ) u_filter (
    .clock    (clock),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .fall_stb (stb),
    .dat_sync (dat)
  );

  ps2_state_e        state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [TOUT_W-1:0] tout_inc;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic              tout_hit;
  logic              par_ok;

`ifdef PS2_PARITY_EN
  logic parity_q, parity_d;
  assign par_ok = odd_parity_ok(shift_q, parity_q);
`else
  assign par_ok = 1'b1;
`endif

  // A strobe always restarts the count, so a timeout can never coincide with a stop bit.
  assign tout_inc = tout_q + TOUT_W'(1);
  assign tout_hit = (state_q != IDLE) && !stb && (tout_inc == TOUT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stb && !dat) state_d = DATA;
      DATA:    if (stb && (bit_cnt_q == 3'd7)) state_d = PARITY;
      PARITY:  if (stb) state_d = STOP;
      STOP:    if (stb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tout_hit) begin
      state_d = IDLE;
    end
  end

  // Datapath and output strobes
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    hit_d     = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_PARITY_EN
    parity_d  = parity_q;
`endif

    if ((state_q == IDLE) || stb || tout_hit) begin
      tout_d = '0;
    end else if (tout_q != TOUT_W'(TIMEOUT)) begin
      tout_d = tout_inc;
    end else begin
      tout_d = tout_q;
    end

    case (state_q)
      IDLE: begin
        if (stb) begin
          if (!dat) begin
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (stb) begin
          // LSB arrives first, so shift toward bit 0.
          shift_d = {dat, shift_q[7:1]};
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
`ifdef PS2_PARITY_EN
        if (stb) begin
          parity_d = dat;
        end
`endif
      end
      STOP: begin
        if (stb) begin
          if (dat && par_ok) begin
            data_d = shift_q;
            hit_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (tout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tout_q    <= '0;
      data_q    <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tout_q    <= tout_d;
      data_q    <= data_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
`ifdef PS2_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ps2_data = data_q;
  assign ps2_hit  = hit_q;
  assign ps2_err  = err_q;

endmodule
